// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory and decode handshake bundle for pc_fetch_unit
//   imem_req/imem_addr  fetch request and word address (fetch unit -> memory)
//   imem_ack/imem_data  completion and instruction word (memory -> fetch unit)
//   id_valid/id_instr/id_pc  buffered instruction to decode (fetch unit -> decode)
//   id_ready            decode accepts (decode -> fetch unit)
//   master modport: the fetch unit; slave modport: memory and decode side
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_pc;
    logic        id_ready;
    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_ack, imem_data, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_ack, imem_data, id_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: 6-bit PC fetch sequencer between instruction memory and decode
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   bus          pc_fetch_unit_if.master: imem req/ack fetch port and id valid/ready port
//   br_take, br_offset    branch redirect to id_pc + INC + signed offset
//   jmp_take, jmp_target  absolute jump redirect, wins over branch
//   halt         suppresses new fetch requests
//   ovf_trap     sticky PC-wrap trap, active only when PC_OVF_TRAP_EN is defined
module pc_fetch_unit #(
    parameter logic [5:0] RESET_PC = 6'd0,
    parameter logic [5:0] INC      = 6'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_fetch_unit_if.master       bus,
    input  logic                  br_take,
    input  logic [5:0]            br_offset,
    input  logic                  jmp_take,
    input  logic [5:0]            jmp_target,
    input  logic                  halt,
    output logic                  ovf_trap
);
    typedef enum logic [1:0] {IDLE, REQ, BUF} state_t;
    state_t      state, state_n;
    logic [5:0]  pc, pc_n, addr, addr_n, id_pc, id_pc_n, target;
    logic [31:0] id_instr, id_instr_n;
    logic        id_valid, id_valid_n, discard, discard_n;
    logic        redir, fetch_ok, stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            addr     <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            id_pc    <= 6'd0;
            discard  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            addr     <= addr_n;
            id_valid <= id_valid_n;
            id_instr <= id_instr_n;
            id_pc    <= id_pc_n;
            discard  <= discard_n;
        end
    end

    always_comb begin
        redir      = jmp_take | br_take;
        // 6-bit wrap makes adding the raw offset equal to adding its sign extension
        target     = jmp_take ? jmp_target : id_pc + INC + br_offset;
        fetch_ok   = (state == REQ) && bus.imem_ack && !discard && !redir;
        state_n    = state;
        pc_n       = pc;
        discard_n  = discard;
        id_valid_n = id_valid;
        id_instr_n = id_instr;
        id_pc_n    = id_pc;
        case (state)
            IDLE: begin
                if (redir) pc_n = target;
                if (!stop) state_n = REQ;
            end
            REQ: begin
                if (fetch_ok) begin
                    id_instr_n = bus.imem_data;
                    id_pc_n    = pc;
                    id_valid_n = 1'b1;
                    pc_n       = pc + INC;
                    state_n    = BUF;
                    discard_n  = 1'b0;
                end else if (bus.imem_ack) begin
                    // stale data from before a redirect is dropped
                    if (redir) pc_n = target;
                    discard_n = 1'b0;
                    state_n   = stop ? IDLE : REQ;
                end else if (redir) begin
                    // the outstanding handshake must still complete at the old address
                    pc_n      = target;
                    discard_n = 1'b1;
                end
            end
            BUF: begin
                if (redir || bus.id_ready) begin
                    id_valid_n = 1'b0;
                    if (redir) pc_n = target;
                    state_n = stop ? IDLE : REQ;
                end
            end
            default: state_n = IDLE;
        endcase
        // the address is latched only when a fresh request starts, so it stays stable while pending
        addr_n = (state_n == REQ && (state != REQ || bus.imem_ack)) ? pc_n : addr;
    end

`ifdef PC_OVF_TRAP_EN
    logic trap;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trap <= 1'b0;
        else if (fetch_ok && (pc > ~INC)) trap <= 1'b1;
    end
    assign ovf_trap = trap;
    assign stop     = halt | trap;
`else
    assign ovf_trap = 1'b0;
    assign stop     = halt;
`endif

    assign bus.imem_req  = state == REQ;
    assign bus.imem_addr = addr;
    assign bus.id_valid  = id_valid;
    assign bus.id_instr  = id_instr;
    assign bus.id_pc     = id_pc;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: self-checking bench for pc_fetch_unit (vector table, directed corners, random vs reference model)
module tb_pc_fetch_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       br_take = 1'b0, jmp_take = 1'b0, halt = 1'b0;
    logic [5:0] br_offset = 6'd0, jmp_target = 6'd0;
    logic       ovf_trap;
    int         checks = 0, failures = 0;
    int         lat = 0, wcnt = 0;

    pc_fetch_unit_if bus();

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .bus(bus),
        .br_take(br_take), .br_offset(br_offset),
        .jmp_take(jmp_take), .jmp_target(jmp_target),
        .halt(halt), .ovf_trap(ovf_trap)
    );

    always #5 clk = ~clk;

    // reference model: occupancy flags for the request and the decode buffer
    int          m_pc;
    logic        m_busy, m_buf, m_poison, m_trap;
    logic [5:0]  m_addr, m_bpc;
    logic [31:0] m_binstr;

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return 32'hC0DE_0000 ^ {a, 2'b00, a, 4'h0, a, 8'h5A};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_busy = 0; m_buf = 0; m_poison = 0; m_trap = 0;
        m_addr = 0; m_bpc = 0; m_binstr = 0;
    endtask

    task automatic model_edge();
        logic stop, redir, start_new;
        int   tgt;
        stop  = halt | m_trap;
        redir = jmp_take | br_take;
        tgt   = jmp_take ? int'(jmp_target)
                         : ((int'(m_bpc) + 1 + int'($signed(br_offset))) % 64 + 64) % 64;
        start_new = 0;
        if (m_busy) begin
            if (bus.imem_ack) begin
                m_busy = 0;
                if (m_poison || redir) begin
                    if (redir) m_pc = tgt;
                    m_poison  = 0;
                    start_new = !stop;
                end else begin
                    m_buf = 1; m_bpc = m_addr; m_binstr = bus.imem_data;
`ifdef PC_OVF_TRAP_EN
                    if (m_pc == 63) m_trap = 1;
`endif
                    m_pc = (m_pc + 1) % 64;
                end
            end else if (redir) begin
                m_pc = tgt; m_poison = 1;
            end
        end else if (m_buf) begin
            if (redir || bus.id_ready) begin
                m_buf = 0;
                if (redir) m_pc = tgt;
                start_new = !stop;
            end
        end else begin
            if (redir) m_pc = tgt;
            start_new = !stop;
        end
        if (start_new) begin m_busy = 1; m_addr = 6'(m_pc); end
    endtask

    task automatic model_check();
        chk("m_req", {31'd0, bus.imem_req}, {31'd0, m_busy});
        if (m_busy) chk("m_addr", {26'd0, bus.imem_addr}, {26'd0, m_addr});
        chk("m_valid", {31'd0, bus.id_valid}, {31'd0, m_buf});
        if (m_buf) begin
            chk("m_id_pc", {26'd0, bus.id_pc}, {26'd0, m_bpc});
            chk("m_id_instr", bus.id_instr, m_binstr);
        end
        chk("m_trap", {31'd0, ovf_trap}, {31'd0, m_trap});
    endtask

    task automatic drive_mem();
        if (bus.imem_req) begin
            if (wcnt >= lat) begin
                bus.imem_ack = 1'b1; bus.imem_data = mem_word(bus.imem_addr); wcnt = 0;
            end else begin
                bus.imem_ack = 1'b0; bus.imem_data = $urandom; wcnt++;
            end
        end else begin
            bus.imem_ack = 1'b0; wcnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        drive_mem();
        model_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_data = 32'd0; bus.id_ready = 1'b0;
        br_take = 0; jmp_take = 0; halt = 0; br_offset = 0; jmp_target = 0;
        wcnt = 0;
        model_reset();
        #2;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_addr", {26'd0, bus.imem_addr}, 32'd0);
        chk("rst_id_pc", {26'd0, bus.id_pc}, 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'd0);
        chk("rst_trap", {31'd0, ovf_trap}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.id_valid && n < budget) begin tick(); n++; end
        chk("wait_valid", {31'd0, bus.id_valid}, 32'd1);
    endtask

    typedef struct {
        logic       ready;
        logic       exp_req;
        logic [5:0] exp_addr;
        logic       exp_valid;
        logic [5:0] exp_pc;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 6'd0, 1'b0, 6'd0};
        tbl[1] = '{1'b1, 1'b1, 6'd0, 1'b0, 6'd0};
        tbl[2] = '{1'b1, 1'b0, 6'd0, 1'b1, 6'd0};
        tbl[3] = '{1'b1, 1'b1, 6'd1, 1'b0, 6'd0};
        tbl[4] = '{1'b1, 1'b0, 6'd0, 1'b1, 6'd1};
        tbl[5] = '{1'b1, 1'b1, 6'd2, 1'b0, 6'd0};
        tbl[6] = '{1'b1, 1'b0, 6'd0, 1'b1, 6'd2};
        tbl[7] = '{1'b1, 1'b1, 6'd3, 1'b0, 6'd0};

        // streaming fetch with zero-wait memory and decode always ready
        lat = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("tbl_req", {31'd0, bus.imem_req}, {31'd0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk("tbl_addr", {26'd0, bus.imem_addr}, {26'd0, tbl[i].exp_addr});
            chk("tbl_valid", {31'd0, bus.id_valid}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk("tbl_id_pc", {26'd0, bus.id_pc}, {26'd0, tbl[i].exp_pc});
                chk("tbl_id_instr", bus.id_instr, mem_word(tbl[i].exp_pc));
            end
            bus.id_ready = tbl[i].ready;
            tick();
        end

        // decode stalls for 5 cycles on the first instruction
        do_reset();
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            bus.id_ready = 1'b0;
            tick();
            chk("stall_valid", {31'd0, bus.id_valid}, 32'd1);
            chk("stall_id_pc", {26'd0, bus.id_pc}, 32'd0);
            chk("stall_instr", bus.id_instr, mem_word(6'd0));
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.id_ready = 1'b1;
        tick();
        chk("release_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("release_req", {31'd0, bus.imem_req}, 32'd1);
        chk("release_addr", {26'd0, bus.imem_addr}, 32'd1);

        // backward branch from the instruction buffered at pc 4
        do_reset();
        bus.id_ready = 1'b1;
        for (int n = 0; n < 30 && !(bus.id_valid && bus.id_pc == 6'd4); n++) tick();
        chk("reach_pc4", {31'd0, bus.id_valid && bus.id_pc == 6'd4}, 32'd1);
        br_take = 1'b1; br_offset = 6'b111110;
        tick();
        br_take = 1'b0;
        chk("br_flush", {31'd0, bus.id_valid}, 32'd0);
        chk("br_req", {31'd0, bus.imem_req}, 32'd1);
        chk("br_addr", {26'd0, bus.imem_addr}, 32'd3);

        // jump while the request waits 3 cycles for its ack
        lat = 3;
        do_reset();
        bus.id_ready = 1'b1;
        tick();
        chk("jr_req0", {31'd0, bus.imem_req}, 32'd1);
        jmp_take = 1'b1; jmp_target = 6'd20;
        tick();
        jmp_take = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("jr_hold_req", {31'd0, bus.imem_req}, 32'd1);
            chk("jr_hold_addr", {26'd0, bus.imem_addr}, 32'd0);
            if (i < 2) tick();
        end
        tick();
        chk("jr_dropped", {31'd0, bus.id_valid}, 32'd0);
        chk("jr_new_req", {31'd0, bus.imem_req}, 32'd1);
        chk("jr_new_addr", {26'd0, bus.imem_addr}, 32'd20);
        wait_valid(10);
        chk("jr_id_pc", {26'd0, bus.id_pc}, 32'd20);
        chk("jr_instr", bus.id_instr, mem_word(6'd20));

        // jump and branch together: jump wins
        lat = 0;
        do_reset();
        bus.id_ready = 1'b0;
        wait_valid(10);
        br_take = 1'b1; br_offset = 6'd5; jmp_take = 1'b1; jmp_target = 6'd9;
        tick();
        br_take = 1'b0; jmp_take = 1'b0;
        chk("bj_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("bj_addr", {26'd0, bus.imem_addr}, 32'd9);

        // halt keeps the unit idle
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
        end
        halt = 1'b0;

        // fetch at 63 wraps the PC
        do_reset();
        bus.id_ready = 1'b1;
        jmp_take = 1'b1; jmp_target = 6'd63;
        tick();
        jmp_take = 1'b0;
        chk("w_addr63", {26'd0, bus.imem_addr}, 32'd63);
        tick();
        chk("w_id_pc", {26'd0, bus.id_pc}, 32'd63);
        tick();
`ifdef PC_OVF_TRAP_EN
        chk("w_trap", {31'd0, ovf_trap}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("w_no_req", {31'd0, bus.imem_req}, 32'd0);
            tick();
        end
`else
        chk("w_trap", {31'd0, ovf_trap}, 32'd0);
        chk("w_req", {31'd0, bus.imem_req}, 32'd1);
        chk("w_addr0", {26'd0, bus.imem_addr}, 32'd0);
`endif

        // asynchronous reset drops a pending request and a buffered instruction
        lat = 3;
        do_reset();
        tick();
        chk("ar_pre_req", {31'd0, bus.imem_req}, 32'd1);
        do_reset();
        lat = 0;
        wait_valid(10);
        do_reset();

        // randomized traffic against the reference model
        for (int blk = 0; blk < 6; blk++) begin
            lat = $urandom_range(0, 3);
            do_reset();
            for (int c = 0; c < 400; c++) begin
                if (c % 50 == 0) lat = $urandom_range(0, 3);
                halt         = ($urandom_range(0, 7) == 0);
                bus.id_ready = ($urandom_range(0, 3) != 0);
                br_take      = ($urandom_range(0, 9) == 0);
                jmp_take     = ($urandom_range(0, 11) == 0);
                br_offset    = 6'($urandom);
                jmp_target   = 6'($urandom);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch sequencer for the MIPS datapath: holds the 6-bit program counter, issues word fetches to instruction memory over a req/ack handshake and hands fetched instructions to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage. It consumes the PC-increment result by advancing the PC after each accepted fetch, and it applies branch and jump redirects coming back from decode/execute.

## Interface
- `RESET_PC`, 6'd0, PC value loaded on reset.
- `INC`, 6'd1, PC increment per fetched instruction, in word units, modulo 64.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `imem_req` out 1: fetch request; once asserted it is held until `imem_ack`.
- `imem_addr` out 6: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: memory completion; `imem_data` is valid in the same cycle.
- `imem_data` in 32: fetched instruction word.
- `id_valid` out 1: instruction available to decode.
- `id_instr` out 32: buffered instruction.
- `id_pc` out 6: address of `id_instr`.
- `id_ready` in 1: decode accepts; the transfer happens on `id_valid & id_ready`.
- `br_take` in 1: branch redirect request.
- `br_offset` in 6: signed word offset for the branch.
- `jmp_take` in 1: jump redirect request.
- `jmp_target` in 6: absolute jump address.
- `halt` in 1: suppresses new fetch requests.
- `ovf_trap` out 1: sticky PC-wrap trap. Driven only when the macro is defined; otherwise tied to 0.

## Operation
- Reset values: `pc`=RESET_PC, state IDLE, `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, `ovf_trap`=0, discard flag=0.
- State IDLE: `imem_req`=0. Move to REQ on the next edge if `halt`=0.
- State REQ: `imem_req`=1 and `imem_addr`=`pc`. When `imem_ack` arrives:
  - If discard=0: capture `imem_data` into `id_instr` and `pc` into `id_pc`, set `id_valid`=1, set `pc`=`pc`+INC, go to BUF.
  - If discard=1: drop the data, clear discard, go to REQ if `halt`=0, else IDLE.
- State BUF: `id_valid` stays 1 and `id_instr`/`id_pc` stay stable until `id_ready`. On the transfer, `id_valid` goes to 0 and the state goes to REQ if `halt`=0, else IDLE.
- Redirect target:
  - `jmp_take`=1 gives `jmp_target`.
  - Otherwise `br_take`=1 gives `id_pc`+INC+sign_extend(`br_offset`) mod 64.
  - Jump wins over branch when both are asserted.
- Redirect handling by state:
  - IDLE: `pc`=target.
  - BUF: `pc`=target, `id_valid` cleared on the next edge (the buffered instruction is flushed even if `id_ready`=1 in the same cycle), next state REQ (or IDLE if `halt`).
  - REQ without `imem_ack`: `pc`=target and discard=1. `imem_req` and `imem_addr` stay unchanged until the ack, because the handshake must complete.
  - REQ with `imem_ack` in the same cycle: the returning data is discarded, `pc`=target, go to REQ/IDLE.
- `halt` never aborts an outstanding request and never clears a buffered instruction.
- Arithmetic is unsigned 6-bit with wrap: 63+1=0. `br_offset` is two's complement, range -32..+31.

## Timing
- Fetch latency: memory address presented in cycle N, ack in cycle N+k, `id_valid` high in cycle N+k+1.
- Peak throughput with zero-wait memory and `id_ready` tied high: one instruction every 2 cycles (REQ, BUF alternating).
- Redirect takes effect on the next edge. The first fetch from the target begins the cycle after the redirect, or the cycle after the pending ack is absorbed.
- Asynchronous `rst` mid-transaction drops `imem_req` and `id_valid` immediately. The memory must tolerate an abandoned request.

## Configuration
- `PC_OVF_TRAP_EN` defined:
  - Any sequential increment that wraps the PC (carry out of bit 5) sets `ovf_trap`=1, sticky until `rst`.
  - While the trap is set the block behaves as if `halt`=1.
  - Redirect-computed wraps do not trap.
- `PC_OVF_TRAP_EN` not defined: the PC wraps silently and `ovf_trap` is constant 0.

## Test plan
- Reset, `halt`=0, memory acks in 1 cycle, `id_ready`=1: `imem_addr` sequence 0,1,2,3; `id_pc` 0,1,2 with matching `id_instr`; `id_valid` pulses every 2nd cycle.
- Hold `id_ready`=0 for 5 cycles after the first instruction: `id_valid`=1, `id_instr`/`id_pc` stable, `imem_req`=0 throughout. Release: transfer occurs, next request has address 1.
- Instruction at `id_pc`=4 in BUF, `br_take`=1, `br_offset`=6'b111110 (-2): next request address is 3 and the buffered instruction is flushed.
- `jmp_take`=1 with `jmp_target`=20 while REQ is pending an ack delayed by 3 cycles: the original address is held until the ack, the data is discarded, then a request at 20 is issued.
- `br_take` and `jmp_take` in the same cycle (`jmp_target`=9): the next fetch is at 9.
- PC=63 with `PC_OVF_TRAP_EN` defined: after fetch at 63, `ovf_trap`=1 and no request at 0. Without the macro, the next request is at 0 and `ovf_trap`=0.
